// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop bit synchronizer with asynchronous clear, for single control bits
// crossing into the clk_i domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the free-running reference clock: debounces lock,
// re-pulses the PLL reset on timeout and sequences the core reset.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned PLL_RST_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT    = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES     = 65536,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked_in,
  output logic             pll_rst,
  output logic             core_rst,
  output logic             lock_ok,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned MAX_LEN = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                          max_u(DEBOUNCE_CYCLES, HOLD_CYCLES));
  localparam int unsigned CW  = $clog2(MAX_LEN) + 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    LD_PLL  = CW'(PLL_RST_CYCLES);
  localparam logic [CW-1:0]    LD_WAIT = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0]    LD_HOLD = CW'(HOLD_CYCLES);
  localparam logic [DBW-1:0]   DB_DONE = DBW'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic           lk_s;
  pll_sup_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DBW-1:0]   db_q, db_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic pll_rst_q, core_rst_q, lock_ok_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (locked_in),
    .q_o   (lk_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    loss_d  = loss_q;
    tmo_d   = tmo_q;
    // Debounce only runs in WAIT_LOCK; any low sample restarts it.
    db_d = '0;
    if (lk_s && state_q == WAIT_LOCK)
      db_d = (db_q == DB_DONE) ? db_q : db_q + 1'b1;

    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == CW'(1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = LD_WAIT;
        end
      end
      WAIT_LOCK: begin
        if (db_q == DB_DONE) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end else if (cnt_q == CW'(1)) begin
          state_d = PLL_RESET;
          cnt_d   = LD_PLL;
          tmo_d   = CNT_W'(sat_inc(32'(tmo_q), 32'(CNT_MAX)));
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = LD_WAIT;
          loss_d  = CNT_W'(sat_inc(32'(loss_q), 32'(CNT_MAX)));
        end else if (cnt_q == CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = LD_WAIT;
          loss_d  = CNT_W'(sat_inc(32'(loss_q), 32'(CNT_MAX)));
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = LD_PLL;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PLL_RESET;
      cnt_q      <= LD_PLL;
      db_q       <= '0;
      loss_q     <= '0;
      tmo_q      <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      lock_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      loss_q     <= loss_d;
      tmo_q      <= tmo_d;
      pll_rst_q  <= (state_d == PLL_RESET);
      core_rst_q <= (state_d != RUN);
      lock_ok_q  <= (state_d == RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_rst      = core_rst_q;
  assign lock_ok       = lock_ok_q;
  assign loss_count    = loss_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters;
// expected values are hand-derived cycle numbers.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       locked_in;
  logic       pll_rst;
  logic       core_rst;
  logic       lock_ok;
  logic [7:0] loss_count;
  logic [7:0] timeout_count;

  int vectors = 0;
  int errs    = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES     (2),
    .PLL_RST_CYCLES  (16),
    .LOCK_TIMEOUT    (200),
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (32),
    .CNT_W           (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .pll_rst       (pll_rst),
    .core_rst      (core_rst),
    .lock_ok       (lock_ok),
    .loss_count    (loss_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; sample point is just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_lock_ok"}, 32'(lock_ok), 32'd0);
    chk({tag, "_loss"}, 32'(loss_count), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_count), 32'd0);
  endtask

  // Releases rst between edges; the caller is then in cycle 0.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    locked_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");

    // Clean start: lock at cycle 30, RUN from cycle 73.
    release_reset();
    for (int c = 0; c <= 75; c++) begin
      chk("cs_pll_rst", 32'(pll_rst), 32'(c <= 15));
      chk("cs_core_rst", 32'(core_rst), 32'(c < 73));
      chk("cs_lock_ok", 32'(lock_ok), 32'(c >= 73));
      if (c == 30) locked_in = 1'b1;
      step();
    end
    chk("cs_loss", 32'(loss_count), 32'd0);
    chk("cs_tmo", 32'(timeout_count), 32'd0);

    // Single-cycle drop in RUN at k=0; core_rst rises at k=3, RUN again at k=44.
    for (int k = 0; k <= 45; k++) begin
      chk("loss_core_rst", 32'(core_rst), 32'(k >= 3 && k < 44));
      chk("loss_lock_ok", 32'(lock_ok), 32'(!(k >= 3 && k < 44)));
      if (k == 3) chk("loss_count1", 32'(loss_count), 32'd1);
      locked_in = (k != 0);
      step();
    end

    // Saturation: 299 more losses, count must stick at 255.
    for (int n = 2; n <= 300; n++) begin
      locked_in = 1'b0;
      step();
      locked_in = 1'b1;
      step();
      step();
      chk("sat_loss", 32'(loss_count), 32'((n > 255) ? 255 : n));
      repeat (41) step();
    end
    step();
    chk("sat_lock_ok", 32'(lock_ok), 32'd1);
    chk("sat_final", 32'(loss_count), 32'd255);

    // Async reset mid-HOLD: drop at k=0, HOLD spans k=12..43.
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    repeat (19) step();
    chk("hold_core_rst", 32'(core_rst), 32'd1);
    chk("hold_lock_ok", 32'(lock_ok), 32'd0);
    chk("hold_pll_rst", 32'(pll_rst), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    locked_in = 1'b0;
    repeat (2) @(posedge clk);

    // No lock: 16-cycle pll_rst pulses every 216 cycles.
    release_reset();
    for (int c = 0; c <= 660; c++) begin
      chk("nl_pll_rst", 32'(pll_rst), 32'((c % 216) < 16));
      chk("nl_tmo", 32'(timeout_count), 32'(c / 216));
      if (c % 8 == 0) chk("nl_core_rst", 32'(core_rst), 32'd1);
      step();
    end

    // Glitchy lock: 5 high / 1 low never completes the debounce.
    rst = 1'b1;
    #1;
    repeat (2) @(posedge clk);
    release_reset();
    for (int c = 0; c <= 440; c++) begin
      chk("gl_tmo", 32'(timeout_count), 32'(c / 216));
      if (c % 4 == 0) begin
        chk("gl_core_rst", 32'(core_rst), 32'd1);
        chk("gl_lock_ok", 32'(lock_ok), 32'd0);
      end
      locked_in = ((c % 6) != 5);
      step();
    end
    chk("gl_loss", 32'(loss_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
